// File: rtl/ender_clock_pkg.sv
// Shared constants and helpers for the ender_clock 24-hour clock core.
// Time fields are held as packed BCD bytes: tens in [7:4], ones in [3:0].
package ender_clock_pkg;

  localparam int NUM_DIGITS = 6;

  // Field limits in packed BCD, so they compare directly against the counters.
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val == max) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/ender_seg7_decoder.sv
// BCD digit to active-high a..g segment pattern; non-decimal codes go blank.
module ender_seg7_decoder
  import ender_clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Segment lookup
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ender_clock.sv
// ender_clock: 24-hour HH:MM:SS clock with set buttons, hold input and a
// multiplexed 6-digit common-cathode 7-segment display.
module ender_clock
  import ender_clock_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [3:0]    sync1_r, sync2_r;
  logic [2:0]    prev_r;
  logic [1:0]    warm_r;
  logic [PW-1:0] pres_r, pres_next_s;
  logic [7:0]    sec_r, min_r, hour_r;
  logic [7:0]    sec_next_s, min_next_s, hour_next_s;
  logic [SW-1:0] scan_cnt_r;
  logic [2:0]    scan_idx_r;
  logic [7:0]    uo_out_r, uio_out_r;

  logic       hold_s, armed_s, tick_s;
  logic [2:0] rise_s;
  logic       hour_inc_s, min_inc_s, sec_clr_s;
  logic       sec_carry_s, min_carry_s;
  logic [3:0] digit_s;
  logic       dp_s;
  logic [5:0] sel_s;
  logic [6:0] seg_s;

  logic unused_s;
  assign unused_s = ^{ena, uio_in, ui_in[7:4]};

  // Input synchronizers, edge-detect history and post-reset arming counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 4'h0;
      sync2_r <= 4'h0;
      prev_r  <= 3'h0;
      warm_r  <= 2'd0;
    end else begin
      sync1_r <= ui_in[3:0];
      sync2_r <= sync1_r;
      prev_r  <= sync2_r[2:0];
      warm_r  <= (warm_r == 2'd3) ? warm_r : warm_r + 2'd1;
    end
  end

  // Edges are only trusted once the synchronizer holds post-reset samples, so a
  // button held through reset release needs a fresh press.
  assign armed_s    = (warm_r == 2'd3);
  assign rise_s     = sync2_r[2:0] & ~prev_r;
  assign hour_inc_s = armed_s & rise_s[0];
  assign min_inc_s  = armed_s & rise_s[1];
  assign sec_clr_s  = armed_s & rise_s[2];
  assign hold_s     = sync2_r[3];
  assign tick_s     = ~hold_s && (pres_r == PRE_LAST);

  // Prescaler and BCD time next-state with button/tick merging
  always_comb begin
    pres_next_s = pres_r;
    sec_next_s  = sec_r;
    min_next_s  = min_r;
    hour_next_s = hour_r;
    sec_carry_s = 1'b0;
    min_carry_s = 1'b0;

    if (sec_clr_s) begin
      pres_next_s = {PW{1'b0}};
      sec_next_s  = 8'h00;
    end else if (tick_s) begin
      pres_next_s = {PW{1'b0}};
      sec_next_s  = bcd_inc(sec_r, SEC_MAX);
      sec_carry_s = (sec_r == SEC_MAX);
    end else if (hold_s) begin
      pres_next_s = pres_r;
    end else begin
      pres_next_s = pres_r + PW'(1'b1);
    end

    // A press and a carry landing together still advance the field only once.
    if (min_inc_s || sec_carry_s) begin
      min_next_s  = bcd_inc(min_r, MIN_MAX);
      min_carry_s = sec_carry_s && (min_r == MIN_MAX);
    end else begin
      min_next_s = min_r;
    end

    if (hour_inc_s || min_carry_s) begin
      hour_next_s = bcd_inc(hour_r, HOUR_MAX);
    end else begin
      hour_next_s = hour_r;
    end
  end

  // Prescaler and time registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_r <= {PW{1'b0}};
      sec_r  <= 8'h00;
      min_r  <= 8'h00;
      hour_r <= 8'h00;
    end else begin
      pres_r <= pres_next_s;
      sec_r  <= sec_next_s;
      min_r  <= min_next_s;
      hour_r <= hour_next_s;
    end
  end

  // Display scan counter and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_r <= {SW{1'b0}};
      scan_idx_r <= 3'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= {SW{1'b0}};
      scan_idx_r <= (scan_idx_r == IDX_LAST) ? 3'd0 : scan_idx_r + 3'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SW'(1'b1);
      scan_idx_r <= scan_idx_r;
    end
  end

  // Digit mux: index 0/1 seconds, 2/3 minutes, 4/5 hours; dp after MM and HH
  always_comb begin
    digit_s = sec_r[3:0];
    dp_s    = 1'b0;
    sel_s   = 6'b000001;
    case (scan_idx_r)
      3'd0: begin digit_s = sec_r[3:0];  sel_s = 6'b000001; end
      3'd1: begin digit_s = sec_r[7:4];  sel_s = 6'b000010; end
      3'd2: begin digit_s = min_r[3:0];  sel_s = 6'b000100; dp_s = 1'b1; end
      3'd3: begin digit_s = min_r[7:4];  sel_s = 6'b001000; end
      3'd4: begin digit_s = hour_r[3:0]; sel_s = 6'b010000; dp_s = 1'b1; end
      3'd5: begin digit_s = hour_r[7:4]; sel_s = 6'b100000; end
      default: begin digit_s = sec_r[3:0]; sel_s = 6'b000001; end
    endcase
  end

  ender_seg7_decoder u_seg7 (
    .bcd (digit_s),
    .seg (seg_s)
  );

  // Registered pin outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uo_out_r  <= 8'h3F;
      uio_out_r <= 8'h01;
    end else begin
      uo_out_r  <= {dp_s, seg_s};
      uio_out_r <= {1'b0, sec_r[0], sel_s};
    end
  end

  assign uo_out  = uo_out_r;
  assign uio_out = uio_out_r;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_ender_clock.sv
// Self-checking bench for ender_clock with a fast 4-cycle second and
// 2-cycle digit scan; a time-of-day model predicts every display output.
module tb_ender_clock;

  localparam int CLK_HZ   = 4;
  localparam int SCAN_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  ender_clock #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;
  bit run_cmp = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Time of day in plain integers plus the last three post-reset pin samples.
  typedef struct {
    int s, m, h, pres, sc, idx, nsamp;
    logic [7:0] q1, q2, q3;
  } model_t;

  model_t mdl;
  logic [7:0] exp_uo, exp_uio;

  function automatic model_t model_reset();
    model_t r;
    r.s = 0; r.m = 0; r.h = 0; r.pres = 0; r.sc = 0; r.idx = 0; r.nsamp = 0;
    r.q1 = 8'h00; r.q2 = 8'h00; r.q3 = 8'h00;
    return r;
  endfunction

  // One clock of the clock's rules: a press acts two samples after the pin
  // sample that showed it rising; hold is seen with the same two-sample delay.
  function automatic model_t step(model_t c, logic [7:0] ui);
    model_t n = c;
    logic [7:0] act;
    logic hold, tick, cmin, chr;
    act  = (c.nsamp >= 3) ? (c.q2 & ~c.q3) : 8'h00;
    hold = (c.nsamp >= 2) ? c.q2[3] : 1'b0;
    tick = !hold && (c.pres == CLK_HZ - 1);
    cmin = 1'b0;
    chr  = 1'b0;
    if (act[2]) begin
      n.s = 0; n.pres = 0;
    end else begin
      if (!hold) n.pres = (c.pres + 1) % CLK_HZ;
      if (tick) begin n.s = (c.s + 1) % 60; cmin = (c.s == 59); end
    end
    if (act[1] || cmin) begin n.m = (c.m + 1) % 60; chr = cmin && (c.m == 59); end
    if (act[0] || chr) n.h = (c.h + 1) % 24;
    if (c.sc == SCAN_DIV - 1) begin n.sc = 0; n.idx = (c.idx + 1) % 6; end
    else n.sc = c.sc + 1;
    n.q3 = c.q2; n.q2 = c.q1; n.q1 = ui;
    n.nsamp = (c.nsamp < 3) ? c.nsamp + 1 : 3;
    return n;
  endfunction

  function automatic logic [7:0] disp_uo(model_t c);
    int d;
    case (c.idx)
      0: d = c.s % 10;
      1: d = c.s / 10;
      2: d = c.m % 10;
      3: d = c.m / 10;
      4: d = c.h % 10;
      default: d = c.h / 10;
    endcase
    return {((c.idx == 2) || (c.idx == 4)) ? 1'b1 : 1'b0, seg_tab[d]};
  endfunction

  function automatic logic [7:0] disp_uio(model_t c);
    logic [5:0] oh;
    oh = 6'b000001 << c.idx;
    return {1'b0, ((c.s % 2) == 1) ? 1'b1 : 1'b0, oh};
  endfunction

  // Model advance; outputs are predicted from the state before each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl     <= model_reset();
      exp_uo  <= 8'h3F;
      exp_uio <= 8'h01;
      cyc     <= 0;
    end else begin
      exp_uo  <= disp_uo(mdl);
      exp_uio <= disp_uio(mdl);
      mdl     <= step(mdl, ui_in);
      cyc     <= cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      check("cyc_uo_out", {24'h0, uo_out}, {24'h0, exp_uo});
      check("cyc_uio_out", {24'h0, uio_out}, {24'h0, exp_uio});
      check("cyc_uio_oe", {24'h0, uio_oe}, 32'h0000_00FF);
    end
  end

  logic [7:0] disp [6];

  task automatic read_display();
    for (int i = 0; i < 6; i++) disp[i] = 8'h00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (uio_out[5:0] == (6'b000001 << i)) disp[i] = uo_out;
      end
    end
  endtask

  task automatic do_reset(input logic [7:0] ui);
    @(negedge clk);
    rst = 1'b1;
    ui_in = ui;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int bitn, input int times);
    for (int k = 0; k < times; k++) begin
      ui_in[bitn] = 1'b1;
      repeat (4) @(negedge clk);
      ui_in[bitn] = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_until(input string name, input int want_s, input int want_pres, input int budget);
    bit hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk);
      if (mdl.s == want_s && (want_pres < 0 || mdl.pres == want_pres)) hit = 1'b1;
    end
    check(name, {31'h0, hit}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int old_m, old_s, old_h, e_clr, rise_at, toggles;
  bit seen_low, prev6;

  initial begin
    // Reset with hold pressed so the display stays at 00:00:00 while read.
    ui_in = 8'h08;
    repeat (3) @(negedge clk);
    run_cmp = 1'b1;
    check("rst_uo_during", {24'h0, uo_out}, 32'h3F);
    check("rst_uio_during", {24'h0, uio_out}, 32'h01);
    rst = 1'b0;
    check("rst_uo_release", {24'h0, uo_out}, 32'h3F);
    check("rst_uio_release", {24'h0, uio_out}, 32'h01);
    check("rst_uio_oe", {24'h0, uio_oe}, 32'hFF);
    read_display();
    for (int i = 0; i < 6; i++)
      check($sformatf("rst_digit%0d", i), {24'h0, disp[i]}, (i == 2 || i == 4) ? 32'hBF : 32'h3F);

    // Free run 60 seconds: one minute exactly.
    do_reset(8'h00);
    repeat (240) @(negedge clk);
    check("count_model_s", mdl.s, 0);
    check("count_model_m", mdl.m, 1);
    check("count_model_h", mdl.h, 0);
    read_display();
    check("count_digit2", {24'h0, disp[2]}, 32'h86);
    check("count_digit3", {24'h0, disp[3]}, 32'h3F);
    check("count_digit4", {24'h0, disp[4]}, 32'hBF);
    prev6 = uio_out[6];
    toggles = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (uio_out[6] != prev6) toggles++;
      prev6 = uio_out[6];
    end
    check("count_sec_lsb_toggles", toggles, 2);

    // Buttons under hold.
    do_reset(8'h08);
    repeat (4) @(negedge clk);
    press(0, 25);
    check("btn_hour_wrap", mdl.h, 1);
    press(1, 61);
    check("btn_min_wrap", mdl.m, 1);
    check("btn_min_no_hour", mdl.h, 1);
    old_s = mdl.s; old_m = mdl.m; old_h = mdl.h;
    repeat (100) @(negedge clk);
    check("hold_s", mdl.s, old_s);
    check("hold_m", mdl.m, old_m);
    check("hold_h", mdl.h, old_h);
    press(1, 1);
    check("hold_min_inc", mdl.m, 2);
    read_display();
    check("hold_digit2", {24'h0, disp[2]}, 32'hDB);
    check("hold_digit4", {24'h0, disp[4]}, 32'h86);

    // sec_clr at :37, prescaler at 2 when it lands; next tick 4 cycles later.
    ui_in = 8'h00;
    wait_until("wait_s37", 37, 0, 400);
    ui_in[2] = 1'b1;
    e_clr = cyc + 3;
    seen_low = 1'b0;
    rise_at = -1;
    for (int k = 0; k < 20 && rise_at < 0; k++) begin
      @(negedge clk);
      if (k == 3) ui_in[2] = 1'b0;
      if (cyc == e_clr) check("secclr_model_s", mdl.s, 0);
      if (!uio_out[6]) seen_low = 1'b1;
      else if (seen_low) rise_at = cyc;
    end
    // tick 4 edges after the clear, then one more edge through the output register
    check("secclr_tick_gap", rise_at - e_clr, 5);
    check("secclr_min_kept", mdl.m, 2);

    // min_inc landing on the tick that wraps 59 -> 00.
    wait_until("wait_s59_a", 59, 1, 400);
    ui_in[1] = 1'b1;
    repeat (4) @(negedge clk);
    ui_in[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("coll_min_once", mdl.m, 3);
    check("coll_min_s", mdl.s, 0);
    check("coll_min_h", mdl.h, 1);

    // sec_clr landing on the wrapping tick discards the carry.
    wait_until("wait_s59_b", 59, 1, 400);
    ui_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    ui_in[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("coll_clr_s", mdl.s, 0);
    check("coll_clr_m", mdl.m, 3);

    // Rollover 23:59:59 -> 00:00:00.
    do_reset(8'h08);
    repeat (4) @(negedge clk);
    press(0, 23);
    press(1, 59);
    check("roll_set_h", mdl.h, 23);
    check("roll_set_m", mdl.m, 59);
    ui_in = 8'h00;
    wait_until("wait_roll_59", 59, -1, 400);
    wait_until("wait_roll_00", 0, -1, 8);
    ui_in[3] = 1'b1;
    check("roll_h", mdl.h, 0);
    check("roll_m", mdl.m, 0);
    check("roll_s", mdl.s, 0);
    repeat (4) @(negedge clk);
    read_display();
    for (int i = 0; i < 6; i++)
      check($sformatf("roll_digit%0d", i), {24'h0, disp[i]}, (i == 2 || i == 4) ? 32'hBF : 32'h3F);

    // Reset in the middle of a press; the held button must not count.
    ui_in = 8'h02;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_no_trigger", mdl.m, 0);
    ui_in[1] = 1'b0;
    repeat (4) @(negedge clk);
    press(1, 1);
    check("rstmid_fresh_press", mdl.m, 1);
    read_display();
    check("rstmid_digit2", {24'h0, disp[2]}, 32'h86);

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ender_clock.md
Name: ender_clock

Overview:
- 24-hour digital clock core (HH:MM:SS) for the TinyTapeout user slot.
- Divides the system clock to a 1 Hz tick and keeps BCD seconds, minutes and hours.
- Accepts three set buttons and a hold input.
- Drives a 6-digit multiplexed common-cathode 7-segment display through the standard TT pin groups.

Parameters:
- CLK_HZ, 50_000_000, system clock cycles per second tick (min 2).
- SCAN_DIV, 50_000, clock cycles each display digit stays selected (min 1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-high.
- ena  input  1  always 1 when powered; ignored.
- ui_in  input  8  [0] hour_inc, [1] min_inc, [2] sec_clr, [3] hold; [7:4] unused.
- uo_out  output  8  [6:0] segments a..g (active-high), [7] decimal point.
- uio_in  input  8  unused.
- uio_out  output  8  [5:0] one-hot digit select, [6] seconds LSB (0.5 Hz square wave), [7] 0.
- uio_oe  output  8  constant 8'hFF.

Behaviour:
- Reset values (asynchronous assert while rst=1):
  - prescaler, seconds, minutes and hours all 0.
  - Scan index and scan counter 0.
  - Synchronizers and edge-detect registers 0.
  - Outputs: uo_out=8'h3F, uio_out=8'h01.
- Input conditioning:
  - Each ui_in bit passes through a 2-FF synchronizer.
  - hour_inc, min_inc and sec_clr are rising-edge detected on the synchronized value, giving a one-cycle pulse.
  - Each action occurs exactly once per press, 3 cycles after the pin rises.
- Prescaler:
  - Counts 0..CLK_HZ-1; tick=1 in the cycle the count equals CLK_HZ-1, then the count wraps to 0.
  - While synchronized hold=1, the prescaler freezes and no ticks occur.
- Time counters (BCD, tens/ones nibbles):
  - On tick: seconds +1. At 59 the seconds wrap to 00 and carry into minutes.
  - Minutes wrap 59→00 and carry into hours.
  - Hours wrap 23→00.
  - Rollover 23:59:59 → 00:00:00 on one tick.
- Buttons:
  - min_inc pulse: minutes +1 mod 60, no carry to hours.
  - hour_inc pulse: hours +1 mod 24.
  - sec_clr pulse: seconds=00 and prescaler=0, no carry.
  - Buttons work regardless of hold.
- Simultaneous events:
  - sec_clr beats tick; the tick's seconds increment and any carry are discarded.
  - A button pulse on a field in the same cycle as a tick carry into that field: the field advances by exactly 1, not 2. Any further carry out of that field is still propagated.
  - Simultaneous hour_inc and min_inc: both apply.
- Display scan:
  - Scan counter counts 0..SCAN_DIV-1; at terminal count the scan index advances 0→1→…→5→0.
  - Digit map:
    - 0 seconds ones, 1 seconds tens.
    - 2 minutes ones, 3 minutes tens.
    - 4 hours ones, 5 hours tens.
  - uio_out[5:0] = 1<<index.
  - uo_out[6:0] = segment code of the selected digit.
  - uo_out[7] = 1 when index is 2 or 4, separating HH.MM.SS; otherwise 0.
  - Outputs are registered and update one cycle after the index or digit value changes.
- Segment codes:
  - 0:3F 1:06 2:5B 3:4F 4:66.
  - 5:6D 6:7D 7:07 8:7F 9:6F.
  - Illegal BCD values show 00.
- Reset mid-operation clears everything immediately, including a press in progress. A button held through reset release does not trigger; it needs a fresh rising edge.

Decomposition:
- Package ender_clock_pkg holds:
  - the ten 7-bit segment constants, and the blank code 7'h00;
  - NUM_DIGITS=6;
  - the limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- One sub-module, ender_seg7_decoder: combinational 4-bit BCD to 7-bit segments, instantiated once after the digit mux.

Test Plan (bench uses CLK_HZ=4, SCAN_DIV=2):
- Reset: after rst 1→0, uo_out=8'h3F, uio_out=8'h01, uio_oe=8'hFF. Time reads 00:00:00 on all digits over 12 cycles of scan.
- Counting: run 60*4 cycles → seconds=00, minutes=01, and digit 2 shows 8'h86 (code for 1 with dp). Run 8 cycles → uio_out[6] toggles twice.
- Rollover: set time to 23:59:59 with button presses plus ticks. One further tick → all six digits show 3F, with dp only on digits 2 and 4.
- Buttons: 25 hour_inc pulses from 00 → hours=01. 61 min_inc pulses → minutes=01, hours unchanged. sec_clr at seconds=37 → seconds=00, with the next tick exactly 4 cycles later.
- Hold: ui_in[3]=1 for 100 cycles → time unchanged. min_inc during hold still increments minutes.
- Collision: min_inc edge aligned with the tick that carries 59→00 seconds → minutes increase by exactly 1. sec_clr aligned with a tick → seconds=00, minutes unchanged.
